// File: rtl/phy_pkg.sv
// Shared PHY definitions: sync header encodings, block-sync FSM states and
// default tuning constants for the 64B/66B receive synchronizer.
`timescale 1ns/1ps

package phy_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT,
        SLIP,
        SLIP_WAIT,
        LOCKED
    } sync_state_t;

    localparam int unsigned LOCK_CNT_DEF  = 64;
    localparam int unsigned ERR_WIN_DEF   = 64;
    localparam int unsigned ERR_MAX_DEF   = 16;
    localparam int unsigned SLIP_WAIT_DEF = 32;

    function automatic logic hdr_legal(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/phy_rx_block_sync.sv
// 64B/66B receive block synchronizer: hunts for header alignment via GT bit
// slips, holds lock under a windowed error budget, and gates payload on lock.
`timescale 1ns/1ps

module phy_rx_block_sync
    import phy_pkg::*;
#(
    parameter int unsigned P_LOCK_CNT  = LOCK_CNT_DEF,
    parameter int unsigned P_ERR_WIN   = ERR_WIN_DEF,
    parameter int unsigned P_ERR_MAX   = ERR_MAX_DEF,
    parameter int unsigned P_SLIP_WAIT = SLIP_WAIT_DEF
) (
    input  logic        i_rx_clk,
    input  logic        i_rx_rst_n,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_valid,
    input  logic [1:0]  i_rx_header,
    input  logic        i_rx_header_valid,
    output logic        o_rx_slipbit,
    output logic        o_block_lock,
    output logic [63:0] o_rx_data,
    output logic [1:0]  o_rx_header,
    output logic        o_rx_valid,
    output logic [7:0]  o_slip_cnt
);

    localparam int unsigned W_SH   = $clog2(P_LOCK_CNT + 1);
    localparam int unsigned W_WIN  = $clog2(P_ERR_WIN + 1);
    localparam int unsigned W_ERR  = $clog2(P_ERR_MAX + 1);
    localparam int unsigned W_WAIT = $clog2(P_SLIP_WAIT + 1);

    localparam logic [W_SH-1:0]   SH_LAST   = W_SH'(P_LOCK_CNT - 1);
    localparam logic [W_WIN-1:0]  WIN_END   = W_WIN'(P_ERR_WIN);
    localparam logic [W_ERR-1:0]  ERR_END   = W_ERR'(P_ERR_MAX);
    localparam logic [W_WAIT-1:0] WAIT_LAST = W_WAIT'(P_SLIP_WAIT - 1);

    sync_state_t        r_state, w_state_nxt;
    logic [W_SH-1:0]    r_sh_cnt, w_sh_nxt;
    logic [W_WIN-1:0]   r_win_cnt, w_win_nxt, w_win_inc;
    logic [W_ERR-1:0]   r_err_cnt, w_err_nxt, w_err_inc;
    logic [W_WAIT-1:0]  r_wait_cnt, w_wait_nxt;
    logic [7:0]         r_slip_cnt, w_slip_nxt;
    logic [63:0]        r_data;
    logic [1:0]         r_hdr;
    logic               r_valid;
    logic               w_legal;

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh_cnt;
        w_win_nxt   = r_win_cnt;
        w_err_nxt   = r_err_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_slip_nxt  = r_slip_cnt;
        w_legal     = hdr_legal(i_rx_header);
        w_win_inc   = r_win_cnt + 1'b1;
        w_err_inc   = w_legal ? r_err_cnt : r_err_cnt + 1'b1;

        unique case (r_state)
            HUNT: begin
                if (i_rx_header_valid) begin
                    if (!w_legal) begin
                        w_state_nxt = SLIP;
                        w_sh_nxt    = '0;
                    end else if (r_sh_cnt == SH_LAST) begin
                        w_state_nxt = LOCKED;
                        w_sh_nxt    = '0;
                        w_win_nxt   = '0;
                        w_err_nxt   = '0;
                    end else begin
                        w_sh_nxt = r_sh_cnt + 1'b1;
                    end
                end
            end
            SLIP: begin
                w_state_nxt = SLIP_WAIT;
                w_wait_nxt  = '0;
                if (r_slip_cnt != '1) begin
                    w_slip_nxt = r_slip_cnt + 1'b1;
                end
            end
            SLIP_WAIT: begin
                // Timer runs on every clock, qualified or not.
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = HUNT;
                    w_wait_nxt  = '0;
                    w_sh_nxt    = '0;
                    w_win_nxt   = '0;
                    w_err_nxt   = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (i_rx_header_valid) begin
                    // Error limit is tested first so it wins on a window boundary.
                    if (w_err_inc == ERR_END) begin
                        w_state_nxt = SLIP;
                        w_win_nxt   = '0;
                        w_err_nxt   = '0;
                    end else if (w_win_inc == WIN_END) begin
                        w_win_nxt = '0;
                        w_err_nxt = '0;
                    end else begin
                        w_win_nxt = w_win_inc;
                        w_err_nxt = w_err_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
        if (!i_rx_rst_n) begin
            r_state    <= HUNT;
            r_sh_cnt   <= '0;
            r_win_cnt  <= '0;
            r_err_cnt  <= '0;
            r_wait_cnt <= '0;
            r_slip_cnt <= '0;
            r_data     <= '0;
            r_hdr      <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh_cnt   <= w_sh_nxt;
            r_win_cnt  <= w_win_nxt;
            r_err_cnt  <= w_err_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_slip_cnt <= w_slip_nxt;
            r_data     <= i_rx_data;
            r_hdr      <= i_rx_header;
            r_valid    <= i_rx_valid && (r_state == LOCKED);
        end
    end

    assign o_rx_slipbit = (r_state == SLIP);
    assign o_block_lock = (r_state == LOCKED);
    assign o_rx_data    = r_data;
    assign o_rx_header  = r_hdr;
    assign o_rx_valid   = r_valid;
    assign o_slip_cnt   = r_slip_cnt;

endmodule

// File: tb/tb_phy_rx_block_sync.sv
// Directed bench for phy_rx_block_sync: lock acquisition, slip/wait timing,
// error-window behaviour, gearbox pauses, slip-count saturation and reset.
`timescale 1ns/1ps

module tb_phy_rx_block_sync;

    logic        clk;
    logic        rst_n;
    logic [63:0] i_rx_data;
    logic        i_rx_valid;
    logic [1:0]  i_rx_header;
    logic        i_rx_header_valid;
    logic        o_rx_slipbit;
    logic        o_block_lock;
    logic [63:0] o_rx_data;
    logic [1:0]  o_rx_header;
    logic        o_rx_valid;
    logic [7:0]  o_slip_cnt;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned slip_seen = 0;
    int unsigned slip_base = 0;
    logic [63:0] last_data;
    logic [1:0]  last_hdr;

    phy_rx_block_sync #(
        .P_LOCK_CNT  (64),
        .P_ERR_WIN   (64),
        .P_ERR_MAX   (16),
        .P_SLIP_WAIT (32)
    ) dut (
        .i_rx_clk          (clk),
        .i_rx_rst_n        (rst_n),
        .i_rx_data         (i_rx_data),
        .i_rx_valid        (i_rx_valid),
        .i_rx_header       (i_rx_header),
        .i_rx_header_valid (i_rx_header_valid),
        .o_rx_slipbit      (o_rx_slipbit),
        .o_block_lock      (o_block_lock),
        .o_rx_data         (o_rx_data),
        .o_rx_header       (o_rx_header),
        .o_rx_valid        (o_rx_valid),
        .o_slip_cnt        (o_slip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle 1ns past the edge.
    task automatic step(input logic [1:0] h, input logic hv, input logic v);
        i_rx_header       = h;
        i_rx_header_valid = hv;
        i_rx_valid        = v;
        i_rx_data         = {cyc, ~cyc ^ 32'h5A5A_1234};
        last_data         = i_rx_data;
        last_hdr          = h;
        cyc++;
        @(posedge clk);
        #1;
        if (o_rx_slipbit) slip_seen++;
    endtask

    task automatic legal_run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_slip"},  64'(o_rx_slipbit), 64'd0);
        check({tag, "_lock"},  64'(o_block_lock), 64'd0);
        check({tag, "_data"},  o_rx_data, 64'd0);
        check({tag, "_hdr"},   64'(o_rx_header), 64'd0);
        check({tag, "_valid"}, 64'(o_rx_valid), 64'd0);
        check({tag, "_scnt"},  64'(o_slip_cnt), 64'd0);
    endtask

    initial begin
        int unsigned q;
        rst_n = 1'b0;
        i_rx_data = '0;
        i_rx_valid = 1'b0;
        i_rx_header = 2'b00;
        i_rx_header_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Gap-free lock acquisition.
        legal_run(63);
        check("lock_pre64", 64'(o_block_lock), 64'd0);
        legal_run(1);
        check("lock_at64", 64'(o_block_lock), 64'd1);
        check("valid_lock_sample", 64'(o_rx_valid), 64'd0);
        check("no_slip_hunt", 64'(slip_seen), 64'd0);
        check("scnt_after_lock", 64'(o_slip_cnt), 64'd0);

        // Two windows with 15 errors each keep lock.
        for (int unsigned w = 0; w < 2; w++) begin
            for (int unsigned i = 0; i < 15; i++) begin
                step(2'b00, 1'b1, 1'b1);
                if (w == 0 && i == 0) begin
                    check("valid_locked", 64'(o_rx_valid), 64'd1);
                    check("data_reg", o_rx_data, last_data);
                    check("hdr_reg", 64'(o_rx_header), 64'(last_hdr));
                end
            end
            legal_run(49);
            check(w == 0 ? "lock_win1" : "lock_win2", 64'(o_block_lock), 64'd1);
        end
        check("no_slip_windows", 64'(slip_seen), 64'd0);

        // 16th error on the 64th window sample: limit beats window clear.
        legal_run(48);
        for (int unsigned i = 0; i < 15; i++) step(2'b11, 1'b1, 1'b1);
        check("lock_15err", 64'(o_block_lock), 64'd1);
        step(2'b11, 1'b1, 1'b1);
        check("lock_drop", 64'(o_block_lock), 64'd0);
        check("slip_with_drop", 64'(o_rx_slipbit), 64'd1);
        check("valid_last_locked", 64'(o_rx_valid), 64'd1);
        step(2'b11, 1'b1, 1'b1);
        check("slip_one_cycle", 64'(o_rx_slipbit), 64'd0);
        check("valid_after_drop", 64'(o_rx_valid), 64'd0);
        check("scnt_1", 64'(o_slip_cnt), 64'd1);

        // Slip wait ignores headers for exactly 32 cycles; hunt restarts from 0.
        for (int unsigned i = 0; i < 32; i++) step(2'b00, 1'b1, 1'b1);
        check("wait_ignored", 64'(slip_seen), 64'd1);
        legal_run(63);
        check("relock_pre", 64'(o_block_lock), 64'd0);
        legal_run(1);
        check("relock", 64'(o_block_lock), 64'd1);

        // Drop lock again, then an illegal header on the 10th hunt sample.
        for (int unsigned i = 0; i < 16; i++) step(2'b00, 1'b1, 1'b1);
        check("slip_16err", 64'(o_rx_slipbit), 64'd1);
        step(2'b00, 1'b1, 1'b1);
        check("scnt_2", 64'(o_slip_cnt), 64'd2);
        for (int unsigned i = 0; i < 32; i++) step(2'b11, 1'b1, 1'b1);
        legal_run(9);
        check("hunt9_noslip", 64'(o_rx_slipbit), 64'd0);
        step(2'b00, 1'b1, 1'b1);
        check("hunt10_slip", 64'(o_rx_slipbit), 64'd1);
        step(2'b00, 1'b1, 1'b1);
        check("hunt10_pulse_end", 64'(o_rx_slipbit), 64'd0);
        check("scnt_3", 64'(o_slip_cnt), 64'd3);
        for (int unsigned i = 0; i < 32; i++) step(2'b00, 1'b1, 1'b1);

        // Gearbox pause one cycle in 33, with garbage header on the pause.
        q = 0;
        for (int unsigned i = 0; i < 67; i++) begin
            if (i % 33 == 32) begin
                step(2'b11, 1'b0, 1'b0);
                if (i == 65) begin
                    check("pause_valid", 64'(o_rx_valid), 64'd0);
                    check("pause_lock", 64'(o_block_lock), 64'd1);
                end
            end else begin
                step((i % 2 == 0) ? 2'b10 : 2'b01, 1'b1, 1'b1);
                q++;
                if (q == 63) check("gb_pre", 64'(o_block_lock), 64'd0);
                if (q == 64) check("gb_lock", 64'(o_block_lock), 64'd1);
                if (i == 66) check("gb_valid", 64'(o_rx_valid), 64'd1);
            end
        end
        check("gb_no_slip", 64'(slip_seen), 64'd3);

        // Slip count saturation over 300 forced slips.
        rst_n = 1'b0;
        #1;
        check_zero("reset2");
        rst_n = 1'b1;
        slip_base = slip_seen;
        for (int unsigned i = 0; i < 300 * 34; i++) step(2'b00, 1'b1, 1'b0);
        check("slips_300", 64'(slip_seen - slip_base), 64'd300);
        check("scnt_sat", 64'(o_slip_cnt), 64'd255);
        legal_run(64);
        check("sat_lock", 64'(o_block_lock), 64'd1);
        check("sat_scnt_locked", 64'(o_slip_cnt), 64'd255);

        // Asynchronous reset while locked and saturated.
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        rst_n = 1'b1;

        // Asynchronous reset during a slip pulse.
        step(2'b11, 1'b1, 1'b1);
        check("pre_rst_slip", 64'(o_rx_slipbit), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_kills_slip", 64'(o_rx_slipbit), 64'd0);
        check("rst_kills_scnt", 64'(o_slip_cnt), 64'd0);
        rst_n = 1'b1;
        legal_run(64);
        check("fresh_lock", 64'(o_block_lock), 64'd1);
        check("fresh_scnt", 64'(o_slip_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
